// File: rtl/pp_loop_pkg.sv
// pp_loop_pkg: shared FSM state encoding and inflight-width helper for the loop monitor
package pp_loop_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  function automatic int if_w(input int m);
    return $clog2(m + 1);
  endfunction
endpackage

// File: rtl/pp_loop_state_match.sv
// pp_loop_state_match: hit=1 when state equals any valid packed entry of states (entry i at [i*FSM_WIDTH +: FSM_WIDTH])
module pp_loop_state_match #(
  parameter int FSM_WIDTH = 2,
  parameter int NUM_POST = 8
) (
  input  logic [FSM_WIDTH-1:0]          state,
  input  logic [NUM_POST-1:0]           valid,
  input  logic [NUM_POST*FSM_WIDTH-1:0] states,
  output logic                          hit
);
  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < NUM_POST; i++)
      hit = hit | (valid[i] && state == states[i*FSM_WIDTH +: FSM_WIDTH]);
  end
endmodule

// File: rtl/pp_loop_monitor.sv
// pp_loop_monitor: tracks pipelined loop iterations of an observed FSM (counts, inflight, high-water mark, post-state hits, done pulse, sticky errors)
module pp_loop_monitor
  import pp_loop_pkg::*;
#(
  parameter int FSM_WIDTH = 2,
  parameter int NUM_POST = 8,
  parameter int CNT_WIDTH = 32,
  parameter int MAX_INFLIGHT = 16,
  localparam int IF_W = if_w(MAX_INFLIGHT)
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [FSM_WIDTH-1:0]          cur_state,
  input  logic [NUM_POST-1:0]           post_states_valid,
  input  logic [NUM_POST*FSM_WIDTH-1:0] post_loop_state,
  input  logic [FSM_WIDTH-1:0]          loop_quit_state,
  input  logic [FSM_WIDTH-1:0]          iter_start_state,
  input  logic [FSM_WIDTH-1:0]          iter_end_state,
  input  logic                          iter_start_enable,
  input  logic                          iter_start_block,
  input  logic                          iter_end_enable,
  input  logic                          iter_end_block,
  input  logic                          quit_at_end,
  input  logic                          finish,
  output logic                          busy,
  output logic [CNT_WIDTH-1:0]          start_cnt,
  output logic [CNT_WIDTH-1:0]          end_cnt,
  output logic [IF_W-1:0]               inflight,
  output logic [IF_W-1:0]               max_inflight,
  output logic                          post_hit,
  output logic                          done,
  output logic                          err_overflow,
  output logic                          err_underflow,
  output logic                          err_incomplete
);
  state_t state, state_n;
  logic start_ev, end_ev, quit_ev, st, en, ovf, unf, active, hit;
  logic [IF_W-1:0] inflight_n;
  pp_loop_state_match #(.FSM_WIDTH(FSM_WIDTH), .NUM_POST(NUM_POST)) u_match (
    .state(cur_state),
    .valid(post_states_valid),
    .states(post_loop_state),
    .hit(hit)
  );
  always_comb begin
    start_ev = cur_state == iter_start_state && iter_start_enable && !iter_start_block;
    end_ev = cur_state == iter_end_state && iter_end_enable && !iter_end_block;
    quit_ev = cur_state == loop_quit_state;
    active = state == RUN || state == DRAIN;
    st = start_ev && (state == IDLE || state == RUN);
    en = end_ev && active;
    ovf = st && !en && inflight == IF_W'(MAX_INFLIGHT);
    unf = en && !st && inflight == '0;
    inflight_n = (ovf || unf || st == en) ? inflight : st ? inflight + 1'b1 : inflight - 1'b1;
    state_n = IDLE;
    case (state)
      IDLE:  state_n = start_ev ? RUN : IDLE;
      RUN:   state_n = finish ? DONE : !quit_ev ? RUN : (quit_at_end && inflight_n != '0) ? DRAIN : DONE;
      DRAIN: state_n = (finish || inflight_n == '0) ? DONE : DRAIN;
      default: state_n = IDLE;
    endcase
    busy = active;
    done = state == DONE;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      inflight <= '0;
      max_inflight <= '0;
      start_cnt <= '0;
      end_cnt <= '0;
      post_hit <= 1'b0;
      err_overflow <= 1'b0;
      err_underflow <= 1'b0;
      err_incomplete <= 1'b0;
    end else begin
      state <= state_n;
      inflight <= inflight_n;
      if (inflight_n > max_inflight) max_inflight <= inflight_n;
      start_cnt <= start_cnt + CNT_WIDTH'(st);
      end_cnt <= end_cnt + CNT_WIDTH'(en);
      post_hit <= hit;
      err_overflow <= err_overflow | ovf;
      err_underflow <= err_underflow | unf;
      err_incomplete <= err_incomplete | (finish && active && inflight != '0);
    end
  end
endmodule

// File: tb/tb_pp_loop_monitor.sv
// tb_pp_loop_monitor: directed scenarios plus random stimulus checked against a behavioural model
module tb_pp_loop_monitor;
  localparam int FW = 2, NP = 8, CW = 4, MI = 4, IW = 3;
  localparam int P_IDLE = 0, P_RUN = 1, P_DRAIN = 2, P_DONE = 3;
  logic clock = 1'b0;
  logic reset;
  logic [FW-1:0] cur_state, loop_quit_state, iter_start_state, iter_end_state;
  logic [NP-1:0] post_states_valid;
  logic [NP*FW-1:0] post_loop_state;
  logic iter_start_enable, iter_start_block, iter_end_enable, iter_end_block, quit_at_end, finish;
  logic busy, post_hit, done, err_overflow, err_underflow, err_incomplete;
  logic [CW-1:0] start_cnt, end_cnt;
  logic [IW-1:0] inflight, max_inflight;
  int errors = 0, checks = 0;
  int m_ph, m_inf, m_max, m_sc, m_ec;
  bit m_ovf, m_unf, m_inc, m_hit;
  always #5 clock = ~clock;
  pp_loop_monitor #(.FSM_WIDTH(FW), .NUM_POST(NP), .CNT_WIDTH(CW), .MAX_INFLIGHT(MI)) dut (
    .clock(clock), .reset(reset), .cur_state(cur_state),
    .post_states_valid(post_states_valid), .post_loop_state(post_loop_state),
    .loop_quit_state(loop_quit_state), .iter_start_state(iter_start_state),
    .iter_end_state(iter_end_state), .iter_start_enable(iter_start_enable),
    .iter_start_block(iter_start_block), .iter_end_enable(iter_end_enable),
    .iter_end_block(iter_end_block), .quit_at_end(quit_at_end), .finish(finish),
    .busy(busy), .start_cnt(start_cnt), .end_cnt(end_cnt), .inflight(inflight),
    .max_inflight(max_inflight), .post_hit(post_hit), .done(done),
    .err_overflow(err_overflow), .err_underflow(err_underflow), .err_incomplete(err_incomplete)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic model();
    bit s, e, q, cs, ce, hit;
    int nf;
    if (reset) begin
      m_ph = P_IDLE; m_inf = 0; m_max = 0; m_sc = 0; m_ec = 0;
      m_ovf = 0; m_unf = 0; m_inc = 0; m_hit = 0;
      return;
    end
    s = cur_state == iter_start_state && iter_start_enable && !iter_start_block;
    e = cur_state == iter_end_state && iter_end_enable && !iter_end_block;
    q = cur_state == loop_quit_state;
    cs = s && (m_ph == P_IDLE || m_ph == P_RUN);
    ce = e && (m_ph == P_RUN || m_ph == P_DRAIN);
    nf = m_inf;
    if (cs && !ce) begin
      if (m_inf == MI) m_ovf = 1; else nf = m_inf + 1;
    end else if (ce && !cs) begin
      if (m_inf == 0) m_unf = 1; else nf = m_inf - 1;
    end
    m_sc = (m_sc + int'(cs)) % (1 << CW);
    m_ec = (m_ec + int'(ce)) % (1 << CW);
    if (nf > m_max) m_max = nf;
    hit = 0;
    for (int i = 0; i < NP; i++)
      if (post_states_valid[i] && post_loop_state[i*FW +: FW] == cur_state) hit = 1;
    m_hit = hit;
    if (m_ph == P_IDLE) m_ph = s ? P_RUN : P_IDLE;
    else if (m_ph == P_DONE) m_ph = P_IDLE;
    else if (finish) begin
      if (m_inf != 0) m_inc = 1;
      m_ph = P_DONE;
    end else if (m_ph == P_RUN) begin
      if (q) m_ph = (quit_at_end && nf != 0) ? P_DRAIN : P_DONE;
    end else if (nf == 0) m_ph = P_DONE;
    m_inf = nf;
  endtask
  task automatic step();
    @(posedge clock);
    model();
    @(negedge clock);
    chk("busy", busy, m_ph == P_RUN || m_ph == P_DRAIN);
    chk("done", done, m_ph == P_DONE);
    chk("start_cnt", start_cnt, m_sc);
    chk("end_cnt", end_cnt, m_ec);
    chk("inflight", inflight, m_inf);
    chk("max_inflight", max_inflight, m_max);
    chk("post_hit", post_hit, m_hit);
    chk("err_overflow", err_overflow, m_ovf);
    chk("err_underflow", err_underflow, m_unf);
    chk("err_incomplete", err_incomplete, m_inc);
  endtask
  task automatic idle();
    reset = 0; finish = 0; iter_start_enable = 0; iter_end_enable = 0;
    iter_start_block = 0; iter_end_block = 0; cur_state = 2'd3;
    iter_start_state = 2'd0; iter_end_state = 2'd1; loop_quit_state = 2'd2;
    post_states_valid = '0; post_loop_state = '0; quit_at_end = 0;
  endtask
  task automatic do_reset();
    idle(); reset = 1; step(); reset = 0;
  endtask
  task automatic starts(input int n);
    cur_state = 2'd0; iter_start_enable = 1;
    repeat (n) step();
    iter_start_enable = 0; cur_state = 2'd3;
  endtask
  task automatic ends(input int n);
    cur_state = 2'd1; iter_end_enable = 1;
    repeat (n) step();
    iter_end_enable = 0; cur_state = 2'd3;
  endtask
  initial begin
    do_reset();
    chk("rst_busy", busy, 0);
    chk("rst_inflight", inflight, 0);
    starts(4);
    cur_state = 2'd2; step(); cur_state = 2'd3;
    chk("quit_now_done", done, 1);
    chk("quit_now_start_cnt", start_cnt, 4);
    chk("quit_now_inflight", inflight, 4);
    step();
    chk("done_one_cycle", done, 0);
    do_reset();
    starts(3);
    quit_at_end = 1; cur_state = 2'd2; step();
    chk("drain_busy", busy, 1);
    chk("drain_no_done", done, 0);
    ends(2);
    chk("drain_held", busy, 1);
    ends(1);
    chk("drain_done", done, 1);
    chk("drain_max", max_inflight, 3);
    chk("drain_inflight", inflight, 0);
    do_reset();
    starts(5);
    chk("ovf_inflight", inflight, 4);
    chk("ovf_flag", err_overflow, 1);
    chk("ovf_start_cnt", start_cnt, 5);
    do_reset();
    starts(2);
    iter_end_state = 2'd0; cur_state = 2'd0; iter_start_enable = 1; iter_end_enable = 1; step();
    idle();
    chk("sim_inflight", inflight, 2);
    chk("sim_start_cnt", start_cnt, 3);
    chk("sim_end_cnt", end_cnt, 1);
    ends(3);
    chk("unf_flag", err_underflow, 1);
    chk("unf_inflight", inflight, 0);
    do_reset();
    starts(2);
    finish = 1; step(); finish = 0;
    chk("fin_done", done, 1);
    chk("fin_incomplete", err_incomplete, 1);
    do_reset();
    starts(2);
    quit_at_end = 1; cur_state = 2'd2; step(); cur_state = 2'd3;
    chk("pre_rst_drain", busy, 1);
    do_reset();
    chk("rst_drain_busy", busy, 0);
    chk("rst_drain_cnt", start_cnt, 0);
    post_states_valid = 8'b0000_0100; post_loop_state[5:4] = 2'b11; cur_state = 2'b11; step();
    chk("post_hit_set", post_hit, 1);
    post_states_valid = '0; step();
    chk("post_hit_clr", post_hit, 0);
    for (int n = 0; n < 3000; n++) begin
      reset = $urandom_range(0, 127) == 0;
      finish = $urandom_range(0, 31) == 0;
      cur_state = FW'($urandom);
      iter_start_state = FW'($urandom);
      iter_end_state = FW'($urandom);
      loop_quit_state = FW'($urandom);
      iter_start_enable = $urandom_range(0, 3) != 0;
      iter_end_enable = $urandom_range(0, 3) != 0;
      iter_start_block = $urandom_range(0, 3) == 0;
      iter_end_block = $urandom_range(0, 3) == 0;
      quit_at_end = 1'($urandom);
      post_states_valid = NP'($urandom);
      post_loop_state = (NP*FW)'($urandom);
      step();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pp_loop_monitor.md
PP_LOOP_MONITOR -- requirements
Module: pp_loop_monitor

Interface
REQ-001 SHALL have parameter FSM_WIDTH, default 2, width of all FSM state ports.
REQ-002 SHALL have parameter NUM_POST, default 8, number of post-loop states (1..16).
REQ-003 SHALL have parameter CNT_WIDTH, default 32, width of iteration counters.
REQ-004 SHALL have parameter MAX_INFLIGHT, default 16, maximum overlapped iterations; IF_W = $clog2(MAX_INFLIGHT+1).
REQ-005 SHALL have ports:
- clock  in  1  single clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- cur_state  in  FSM_WIDTH  DUT FSM state sampled each cycle.
- post_states_valid  in  NUM_POST  per-entry valid for post_loop_state.
- post_loop_state  in  NUM_POST*FSM_WIDTH  packed post-loop states; entry i in bits [i*FSM_WIDTH +: FSM_WIDTH].
- loop_quit_state  in  FSM_WIDTH  state signalling loop exit request.
- iter_start_state, iter_end_state  in  FSM_WIDTH  iteration start/end states.
- iter_start_enable, iter_start_block, iter_end_enable, iter_end_block  in  1  event qualifiers.
- quit_at_end  in  1  1: quit waits for pipeline drain; 0: quit immediate.
- finish  in  1  simulation finish; forces completion.
- busy  out  1  loop active (RUN or DRAIN).
- start_cnt, end_cnt  out  CNT_WIDTH  iterations started/ended since reset.
- inflight  out  IF_W  iterations started but not ended.
- max_inflight  out  IF_W  high-water mark of inflight.
- post_hit  out  1  cur_state matched a valid post-loop state last cycle.
- done  out  1  one-cycle pulse on loop completion.
- err_overflow, err_underflow, err_incomplete  out  1  sticky error flags.

Function
REQ-006 SHALL define start_ev = (cur_state==iter_start_state) & iter_start_enable & ~iter_start_block; end_ev likewise with iter_end_*; quit_ev = (cur_state==loop_quit_state).
REQ-007 SHALL implement states IDLE, RUN, DRAIN, DONE; IDLE->RUN on start_ev; RUN->DRAIN on quit_ev when quit_at_end=1 and next inflight!=0; RUN->DONE on quit_ev otherwise; DRAIN->DONE when next inflight==0; DONE->IDLE unconditionally after one cycle.
REQ-008 SHALL count start_ev only in IDLE/RUN and end_ev only in RUN/DRAIN; all outputs registered, reflecting events of the previous cycle (latency 1).
REQ-009 SHALL update inflight +1 on start_ev alone, -1 on end_ev alone, unchanged on simultaneous start_ev and end_ev.
REQ-010 SHALL saturate inflight at MAX_INFLIGHT and set err_overflow when start_ev alone occurs at MAX_INFLIGHT.
REQ-011 SHALL hold inflight at 0 and set err_underflow when end_ev alone occurs at inflight 0.
REQ-012 SHALL wrap start_cnt and end_cnt modulo 2^CNT_WIDTH without error.
REQ-013 SHALL update max_inflight to inflight's next value whenever larger.
REQ-014 SHALL assert post_hit when cur_state equals any post_loop_state[i] with post_states_valid[i]=1, in any state.
REQ-015 SHALL assert done for exactly the cycle the FSM is in DONE; busy=1 in RUN and DRAIN only.
REQ-016 SHALL on finish=1 in RUN or DRAIN go to DONE, setting err_incomplete if inflight!=0; finish in IDLE/DONE has no effect.
REQ-017 SHALL give finish priority over quit_ev and start_ev in the same cycle; quit_ev in IDLE is ignored.

Reset
REQ-018 SHALL on reset=1 at a clock edge set FSM to IDLE and all outputs, counters, high-water mark and error flags to 0, overriding all events that cycle.

Structure
REQ-019 SHALL place the FSM state enum and IF_W helper function in shared package pp_loop_pkg.
REQ-020 SHALL implement the post-state comparison in sub-module pp_loop_state_match (parameters FSM_WIDTH, NUM_POST; output hit).

Verification
REQ-021 Reset, then 5 start_ev one per cycle, quit_ev with quit_at_end=0 -> start_cnt=5, DONE next cycle, done pulse 1 cycle, inflight=5.
REQ-022 quit_at_end=1: 3 starts, quit_ev, then 3 end_ev -> DRAIN until third end, done one cycle later, max_inflight=3, inflight=0.
REQ-023 MAX_INFLIGHT=4: 5 starts no ends -> inflight=4, err_overflow=1, start_cnt=5.
REQ-024 Simultaneous start_ev+end_ev at inflight=2 -> inflight stays 2, both counters +1; end_ev at inflight 0 in RUN -> err_underflow=1.
REQ-025 finish with inflight=2 in RUN -> done pulse, err_incomplete=1; reset mid-DRAIN -> all outputs 0 next cycle, FSM IDLE.
REQ-026 post_states_valid=8'b0000_0100, post_loop_state[2]=2'b11, cur_state=2'b11 -> post_hit=1 next cycle; with valid bit cleared -> post_hit=0.
